biriscv_fetch_queue: RTL and testbench
======================================

# biriscv_fetch_queue

Parametrised instruction queue between the fetch unit and decode. Accepts aligned fetch packets of FETCH_WORDS 32-bit instructions each. Strips slots that precede the fetch PC or follow a predicted-taken branch, then buffers the packets. Presents up to two in-order instructions per cycle to the dual-issue decode ports, and can pair slots across two adjacent packets. It generalises the fixed 64-bit, single-packet fetch/decode hand-off, adding configurable packet width and depth, cross-packet pairing and flush.

## Interface
Parameters:
- FETCH_WORDS, 2: instructions per fetch packet; 2 or 4.
- DEPTH, 4: packet entries; power of two, ≥2.
- DEPTH_W, 2: log2(DEPTH).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- fetch_valid_i  in  1  packet offered.
- fetch_instr_i  in  32*FETCH_WORDS  packet; slot k is bits [32k+31:32k].
- fetch_pc_i  in  32  PC of first wanted instruction; bits [1:0]=0.
- fetch_pred_branch_i  in  FETCH_WORDS  bit k: slot k predicted taken.
- fetch_fault_fetch_i  in  1  bus error on this packet.
- fetch_fault_page_i  in  1  page fault on this packet.
- fetch_accept_o  out  1  packet taken when valid&accept.
- branch_request_i  in  1  flush (redirect).
- out0_valid_o, out1_valid_o  out  1  slot presented.
- out0_instr_o, out1_instr_o  out  32  instruction.
- out0_pc_o, out1_pc_o  out  32  instruction PC.
- out0_fault_fetch_o, out0_fault_page_o, out1_fault_fetch_o, out1_fault_page_o  out  1  fault flags.
- out0_accept_i, out1_accept_i  in  1  decode consumes slot.

## Operation
- Push: on valid&accept, write the entry at the tail. Stored per entry:
  - packet;
  - base PC = fetch_pc_i with bits [log2(FETCH_WORDS)+1:0] cleared;
  - slot mask.
- Slot mask: bit k = 1 iff k ≥ off and no pred_branch bit j is set with off ≤ j < k, where off = fetch_pc_i[log2(FETCH_WORDS)+1:2].
- Fault packet: only slot off is set; its instr is stored as 0 and its fault flags are stored.
- fetch_accept_o = (count != DEPTH). There is no push-when-full, even if a pop occurs in the same cycle.
- Presentation:
  - out0 = lowest set slot of the head entry.
  - out1 = next set slot of the head entry; if none exists, the lowest set slot of entry head+1 (if occupied).
  - slot PC = base + 4·k.
- Pop:
  - out0_accept_i clears the out0 slot bit.
  - out1_accept_i clears the out1 slot bit only when out0_accept_i is also high; otherwise it is ignored.
  - An entry whose mask becomes 0 is retired, and head advances. Head may advance by 2 in one cycle (head fully drained and head+1's only slot taken).
- Pointers are DEPTH_W bits and wrap modulo DEPTH. count is DEPTH_W+1 bits: count' = count + push − retired.
- Flush: branch_request_i clears all masks and pointers at the edge. A push or pop in the same cycle is discarded. Flush has priority over reset-free state only; rst_i has priority over everything.
- Outputs are driven from stored state only; there is no input-to-output combinational path except the accept gating of out1.

## Timing
- Reset values: all out*_valid_o=0, instr/pc/fault outputs=0, fetch_accept_o=1, count=0.
- Latency: packet pushed at edge N is visible on out0 in cycle N+1 if the queue was empty.
- A pop at edge N shows the next slots in cycle N+1; sustained throughput is 2 instr/cycle.
- Full: with count=DEPTH, fetch_accept_o=0. It returns to 1 the cycle after any retirement.
- Empty: both valids are 0. out1_valid_o=0 when the head has one slot and head+1 is empty.
- A flush at edge N gives all valids 0 and fetch_accept_o=1 in N+1.
- An all-zero mask (off beyond a predicted branch cannot occur) is still stored and retired in the next cycle without presentation. The verifier checks that this never stalls.

## Structure
- Shared package: FETCH_WORDS-derived widths, the entry record (packet, base PC, mask, fault bits), and the instruction-slot width constant 32.
- Sub-module biriscv_slot_pick: combinational find-first/find-second set bit over a FETCH_WORDS mask, returning index and found flags. It is instantiated for the head and head+1 entries.

## Test plan
- Push pc=0x1000, FETCH_WORDS=2, no branch; accept both -> out0 pc 0x1000 and out1 0x1004 in cycle N+1, queue empty in N+2.
- Push pc=0x1004 (off=1), then pc=0x1008 -> cycle 1: out0=0x1004, out1=0x1008, cross-packet; accept both -> out0=0x100C, out1_valid=0.
- FETCH_WORDS=4, pc=0x2000, pred_branch=4'b0010 -> only 0x2000 and 0x2004 are presented; slots 2 and 3 are never presented.
- Fill DEPTH=4 with no pops -> fetch_accept_o=0 after the 4th push, a 5th offered packet is not stored, and accept=1 the cycle after one packet retires; the pointer wraps correctly over 3 fill/drain rounds.
- With 3 packets queued, assert branch_request_i together with fetch_valid_i and out0_accept_i -> cycle N+1 has all valids 0, count 0, and the pushed packet is absent.
- Fault packet pc=0x3004 with fault_page=1 -> single out0 with pc 0x3004, instr 0, fault_page=1 and out1_valid=0 (queue otherwise empty); out1_accept_i alone is ignored.

Source files
------------

// File: rtl/biriscv_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// biriscv_fetch_queue_pkg
// Shared types and constants for the fetch queue.
//   INSTR_W          width of one instruction slot
//   MAX_FETCH_WORDS  widest supported fetch packet (entries are sized for it)
//   entry_t          one buffered packet: raw packet, base PC, slot mask, faults
//   off_width()      bits needed to index a slot within a FETCH_WORDS packet
// -----------------------------------------------------------------------------
package biriscv_fetch_queue_pkg;

    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned MAX_FETCH_WORDS = 4;

    typedef struct packed {
        logic [MAX_FETCH_WORDS*INSTR_W-1:0] packet;
        logic [31:0]                        base_pc;
        logic [MAX_FETCH_WORDS-1:0]         mask;
        logic                               fault_fetch;
        logic                               fault_page;
    } entry_t;

    function automatic int unsigned off_width(input int unsigned fetch_words);
        return (fetch_words > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/biriscv_fetch_queue_slot_pick.sv
// -----------------------------------------------------------------------------
// biriscv_slot_pick
// Combinational find-first / find-second set bit over a slot mask.
//   mask          slot-valid bits, bit 0 is the oldest slot
//   first_idx     index of the lowest set bit   (valid when first_found)
//   second_idx    index of the next set bit     (valid when second_found)
// -----------------------------------------------------------------------------
module biriscv_slot_pick #(
    parameter int unsigned W     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [W-1:0]     mask,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_found,
    output logic [IDX_W-1:0] second_idx,
    output logic             second_found
);

    always_comb begin
        first_idx    = '0;
        first_found  = 1'b0;
        second_idx   = '0;
        second_found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (mask[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = IDX_W'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/biriscv_fetch_queue.sv
// -----------------------------------------------------------------------------
// biriscv_fetch_queue
// Instruction queue between fetch and dual-issue decode. Buffers DEPTH fetch
// packets, trims slots before the fetch PC and after a predicted-taken branch,
// and presents up to two in-order instructions per cycle, pairing across the
// head and head+1 packets when the head has only one slot left.
//   clk_i / rst_i              clock, synchronous active-high reset
//   fetch_*_i / fetch_accept_o packet push handshake
//   branch_request_i           flush all buffered packets
//   out0_* / out1_*            decode slots; outN_accept_i consumes the slot
// -----------------------------------------------------------------------------
module biriscv_fetch_queue
    import biriscv_fetch_queue_pkg::*;
#(
    parameter int unsigned FETCH_WORDS = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DEPTH_W     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           fetch_valid_i,
    input  logic [FETCH_WORDS*INSTR_W-1:0] fetch_instr_i,
    input  logic [31:0]                    fetch_pc_i,
    input  logic [FETCH_WORDS-1:0]         fetch_pred_branch_i,
    input  logic                           fetch_fault_fetch_i,
    input  logic                           fetch_fault_page_i,
    output logic                           fetch_accept_o,
    input  logic                           branch_request_i,
    output logic                           out0_valid_o,
    output logic [31:0]                    out0_instr_o,
    output logic [31:0]                    out0_pc_o,
    output logic                           out0_fault_fetch_o,
    output logic                           out0_fault_page_o,
    input  logic                           out0_accept_i,
    output logic                           out1_valid_o,
    output logic [31:0]                    out1_instr_o,
    output logic [31:0]                    out1_pc_o,
    output logic                           out1_fault_fetch_o,
    output logic                           out1_fault_page_o,
    input  logic                           out1_accept_i
);

    localparam int unsigned OFF_W    = off_width(FETCH_WORDS);
    localparam int unsigned PKT_W    = FETCH_WORDS * INSTR_W;
    localparam logic [31:0] BASE_LOW = 32'((1 << (OFF_W + 2)) - 1);

    entry_t               mem [DEPTH];
    logic [DEPTH_W-1:0]   head;
    logic [DEPTH_W-1:0]   tail;
    logic [DEPTH_W-1:0]   head_next;
    logic [DEPTH_W:0]     count;

    // ---------------- push side ----------------
    logic [OFF_W-1:0] push_off;
    logic             blocked;
    entry_t           push_entry;
    logic             push;

    always_comb begin
        push_off               = fetch_pc_i[OFF_W+1:2];
        blocked                = 1'b0;
        push_entry             = '0;
        push_entry.base_pc     = fetch_pc_i & ~BASE_LOW;
        push_entry.fault_fetch = fetch_fault_fetch_i;
        push_entry.fault_page  = fetch_fault_page_i;
        if (fetch_fault_fetch_i || fetch_fault_page_i) begin
            push_entry.mask[push_off] = 1'b1;
        end else begin
            push_entry.packet[PKT_W-1:0] = fetch_instr_i;
            // A predicted branch at slot j keeps slot j but blocks every later slot.
            for (int unsigned k = 0; k < FETCH_WORDS; k++) begin
                if (k >= 32'(push_off)) begin
                    push_entry.mask[k] = !blocked;
                    if (fetch_pred_branch_i[k]) blocked = 1'b1;
                end
            end
        end
    end

    assign fetch_accept_o = (count != (DEPTH_W+1)'(DEPTH));
    assign push           = fetch_valid_i && fetch_accept_o;

    // ---------------- presentation ----------------
    entry_t           head_entry;
    entry_t           next_entry;
    logic             head_occ;
    logic             next_occ;
    logic [OFF_W-1:0] h_idx0, h_idx1, n_idx0, n_idx1;
    logic             h_found0, h_found1, n_found0, n_found1;

    assign head_next  = head + DEPTH_W'(1);
    assign head_entry = mem[head];
    assign next_entry = mem[head_next];
    assign head_occ   = (count != '0);
    assign next_occ   = (count > (DEPTH_W+1)'(1));

    biriscv_slot_pick #(.W(FETCH_WORDS), .IDX_W(OFF_W)) u_pick_head (
        .mask         (head_entry.mask[FETCH_WORDS-1:0]),
        .first_idx    (h_idx0),
        .first_found  (h_found0),
        .second_idx   (h_idx1),
        .second_found (h_found1)
    );

    biriscv_slot_pick #(.W(FETCH_WORDS), .IDX_W(OFF_W)) u_pick_next (
        .mask         (next_entry.mask[FETCH_WORDS-1:0]),
        .first_idx    (n_idx0),
        .first_found  (n_found0),
        .second_idx   (n_idx1),
        .second_found (n_found1)
    );

    logic             v0, v1, pair_in_head;
    entry_t           e1;
    logic [OFF_W-1:0] idx1;

    assign v0           = head_occ && h_found0;
    assign pair_in_head = h_found1;
    assign v1           = v0 && (pair_in_head || (next_occ && n_found0));
    assign e1           = pair_in_head ? head_entry : next_entry;
    assign idx1         = pair_in_head ? h_idx1 : n_idx0;

    assign out0_valid_o       = v0;
    assign out0_instr_o       = v0 ? head_entry.packet[32'(h_idx0)*INSTR_W +: INSTR_W] : '0;
    assign out0_pc_o          = v0 ? head_entry.base_pc + (32'(h_idx0) << 2) : '0;
    assign out0_fault_fetch_o = v0 && head_entry.fault_fetch;
    assign out0_fault_page_o  = v0 && head_entry.fault_page;

    assign out1_valid_o       = v1;
    assign out1_instr_o       = v1 ? e1.packet[32'(idx1)*INSTR_W +: INSTR_W] : '0;
    assign out1_pc_o          = v1 ? e1.base_pc + (32'(idx1) << 2) : '0;
    assign out1_fault_fetch_o = v1 && e1.fault_fetch;
    assign out1_fault_page_o  = v1 && e1.fault_page;

    // ---------------- pop / retire ----------------
    logic                       take0, take1;
    logic [MAX_FETCH_WORDS-1:0] head_mask_new, next_mask_new;
    logic                       retire_head, retire_next;
    logic [1:0]                 retired;

    // out1 is only honoured together with out0 so consumption stays in order.
    assign take0 = v0 && out0_accept_i;
    assign take1 = v1 && out1_accept_i && out0_accept_i;

    always_comb begin
        head_mask_new = head_entry.mask;
        next_mask_new = next_entry.mask;
        if (take0) head_mask_new[h_idx0] = 1'b0;
        if (take1 && pair_in_head) head_mask_new[h_idx1] = 1'b0;
        if (take1 && !pair_in_head) next_mask_new[n_idx0] = 1'b0;
    end

    // An empty head (including one stored with a zero mask) retires without
    // being presented; head+1 can only retire alongside it.
    assign retire_head = head_occ && (head_mask_new == '0);
    assign retire_next = retire_head && next_occ && (next_mask_new == '0);
    assign retired     = {1'b0, retire_head} + {1'b0, retire_next};

    always_ff @(posedge clk_i) begin
        if (rst_i || branch_request_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i].mask <= '0;
        end else begin
            // tail never aliases an occupied head/head+1 entry while push is allowed
            if (head_occ) mem[head].mask <= head_mask_new;
            if (next_occ) mem[head_next].mask <= next_mask_new;
            if (push) begin
                mem[tail] <= push_entry;
                tail      <= tail + DEPTH_W'(1);
            end
            head  <= head + DEPTH_W'(retired);
            count <= count + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(retired);
        end
    end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
module tb_biriscv_fetch_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ff;
        logic        fp;
    } slot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // FETCH_WORDS=2 instance (scoreboarded)
    logic        fv, ffe, fpg, facc, br, a0, a1;
    logic [63:0] finstr;
    logic [31:0] fpc;
    logic [1:0]  fpred;
    logic        o0v, o1v, o0ff, o0fp, o1ff, o1fp;
    logic [31:0] o0i, o1i, o0p, o1p;

    // FETCH_WORDS=4 instance (directed)
    logic         fv4, facc4, a04, a14;
    logic [127:0] finstr4;
    logic [31:0]  fpc4;
    logic [3:0]   fpred4;
    logic         o0v4, o1v4, o0ff4, o0fp4, o1ff4, o1fp4;
    logic [31:0]  o0i4, o1i4, o0p4, o1p4;

    biriscv_fetch_queue #(.FETCH_WORDS(2), .DEPTH(4), .DEPTH_W(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fv), .fetch_instr_i(finstr), .fetch_pc_i(fpc),
        .fetch_pred_branch_i(fpred), .fetch_fault_fetch_i(ffe), .fetch_fault_page_i(fpg),
        .fetch_accept_o(facc), .branch_request_i(br),
        .out0_valid_o(o0v), .out0_instr_o(o0i), .out0_pc_o(o0p),
        .out0_fault_fetch_o(o0ff), .out0_fault_page_o(o0fp), .out0_accept_i(a0),
        .out1_valid_o(o1v), .out1_instr_o(o1i), .out1_pc_o(o1p),
        .out1_fault_fetch_o(o1ff), .out1_fault_page_o(o1fp), .out1_accept_i(a1)
    );

    biriscv_fetch_queue #(.FETCH_WORDS(4), .DEPTH(4), .DEPTH_W(2)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fv4), .fetch_instr_i(finstr4), .fetch_pc_i(fpc4),
        .fetch_pred_branch_i(fpred4), .fetch_fault_fetch_i(1'b0), .fetch_fault_page_i(1'b0),
        .fetch_accept_o(facc4), .branch_request_i(1'b0),
        .out0_valid_o(o0v4), .out0_instr_o(o0i4), .out0_pc_o(o0p4),
        .out0_fault_fetch_o(o0ff4), .out0_fault_page_o(o0fp4), .out0_accept_i(a04),
        .out1_valid_o(o1v4), .out1_instr_o(o1i4), .out1_pc_o(o1p4),
        .out1_fault_fetch_o(o1ff4), .out1_fault_page_o(o1fp4), .out1_accept_i(a14)
    );

    int    checks   = 0;
    int    failures = 0;
    slot_t sb[$];     // expected slots, oldest first
    int    ents[$];   // remaining slot count per buffered packet

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]} ^ {pc[31:16], 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out0_valid", {31'd0, o0v}, {31'd0, sb.size() >= 1});
        if (sb.size() >= 1) begin
            chk("out0_pc", o0p, sb[0].pc);
            chk("out0_instr", o0i, sb[0].instr);
            chk("out0_fault_fetch", {31'd0, o0ff}, {31'd0, sb[0].ff});
            chk("out0_fault_page", {31'd0, o0fp}, {31'd0, sb[0].fp});
        end else begin
            chk("out0_pc_idle", o0p, 32'h0);
            chk("out0_instr_idle", o0i, 32'h0);
        end
        chk("out1_valid", {31'd0, o1v}, {31'd0, sb.size() >= 2});
        if (sb.size() >= 2) begin
            chk("out1_pc", o1p, sb[1].pc);
            chk("out1_instr", o1i, sb[1].instr);
            chk("out1_fault_page", {31'd0, o1fp}, {31'd0, sb[1].fp});
        end else begin
            chk("out1_pc_idle", o1p, 32'h0);
        end
        chk("fetch_accept", {31'd0, facc}, {31'd0, ents.size() != 4});
    endtask

    // One cycle: check current outputs, drive inputs, advance, update the model.
    task automatic step(input bit push, input logic [31:0] pc, input logic [1:0] pred,
                        input bit f_fetch, input bit f_page,
                        input bit acc0, input bit acc1, input bit flush);
        int          npop;
        bit          will_push;
        int          off;
        int          cnt;
        bit          stop;
        logic [31:0] base;
        check_outputs();
        base = {pc[31:3], 3'b000};
        fv = push; fpc = pc; fpred = pred; ffe = f_fetch; fpg = f_page;
        finstr = {mk_instr(base + 32'd4), mk_instr(base)};
        a0 = acc0; a1 = acc1; br = flush;
        will_push = push && (ents.size() != 4);
        npop = 0;
        if (acc0 && sb.size() >= 1) npop = (acc1 && sb.size() >= 2) ? 2 : 1;
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
            ents.delete();
        end else begin
            for (int i = 0; i < npop; i++) begin
                void'(sb.pop_front());
                ents[0] = ents[0] - 1;
                if (ents[0] == 0) void'(ents.pop_front());
            end
            if (will_push) begin
                off = int'(pc[2]);
                cnt = 0;
                if (f_fetch || f_page) begin
                    sb.push_back('{base + 32'(off * 4), 32'h0, f_fetch, f_page});
                    cnt = 1;
                end else begin
                    stop = 1'b0;
                    for (int k = off; k < 2; k++) begin
                        if (!stop) begin
                            sb.push_back('{base + 32'(k * 4), mk_instr(base + 32'(k * 4)), 1'b0, 1'b0});
                            cnt++;
                            if (pred[k]) stop = 1'b1;
                        end
                    end
                end
                ents.push_back(cnt);
            end
        end
        fv = 1'b0; a0 = 1'b0; a1 = 1'b0; br = 1'b0; ffe = 1'b0; fpg = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_pc(input logic [31:0] pc);
        step(1'b1, pc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic take2();
        step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        fv = 0; finstr = '0; fpc = '0; fpred = '0; ffe = 0; fpg = 0; br = 0; a0 = 0; a1 = 0;
        fv4 = 0; finstr4 = '0; fpc4 = '0; fpred4 = '0; a04 = 0; a14 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_out0_valid4", {31'd0, o0v4}, 32'd0);
        chk("rst_accept4", {31'd0, facc4}, 32'd1);
        idle();

        // aligned packet, consume both
        push_pc(32'h1000);
        idle();
        take2();
        idle();

        // offset packet, then cross-packet pairing
        push_pc(32'h1004);
        push_pc(32'h1008);
        idle();
        take2();
        idle();
        step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // fill / full / retire / drain over three rounds (pointer wrap)
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++)
                push_pc(32'h4000 + 32'(r * 256) + 32'(i * 8) + ((r == 1) ? 32'd4 : 32'd0));
            take2();
            for (int i = 0; i < 5; i++) take2();
            idle();
        end

        // flush beats a same-cycle push and pop
        push_pc(32'h5000);
        push_pc(32'h5008);
        push_pc(32'h5010);
        step(1'b1, 32'h5018, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        push_pc(32'h6000);
        idle();
        take2();
        idle();

        // fault packet: single slot, instr 0; out1_accept alone ignored
        step(1'b1, 32'h3004, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // mixed traffic
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 32'h8000 + 32'($urandom_range(0, 63) * 4),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 6; i++) take2();
        idle();

        // FETCH_WORDS=4: predicted branch in slot 1 drops slots 2 and 3
        fv4 = 1'b1; fpc4 = 32'h2000; fpred4 = 4'b0010;
        finstr4 = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
        @(posedge clk); #1;
        fv4 = 1'b0;
        chk("w4_out0_valid", {31'd0, o0v4}, 32'd1);
        chk("w4_out0_pc", o0p4, 32'h2000);
        chk("w4_out0_instr", o0i4, 32'hD0D0D0D0);
        chk("w4_out1_valid", {31'd0, o1v4}, 32'd1);
        chk("w4_out1_pc", o1p4, 32'h2004);
        chk("w4_out1_instr", o1i4, 32'hD1D1D1D1);
        a04 = 1'b1; a14 = 1'b1;
        @(posedge clk); #1;
        a04 = 1'b0; a14 = 1'b0;
        chk("w4_drained_out0", {31'd0, o0v4}, 32'd0);
        chk("w4_drained_out1", {31'd0, o1v4}, 32'd0);
        @(posedge clk); #1;
        chk("w4_still_empty", {31'd0, o0v4}, 32'd0);

        // FETCH_WORDS=4: offset 2, no branch
        fv4 = 1'b1; fpc4 = 32'h2008; fpred4 = 4'b0000;
        @(posedge clk); #1;
        fv4 = 1'b0;
        chk("w4_off2_out0_pc", o0p4, 32'h2008);
        chk("w4_off2_out0_instr", o0i4, 32'hD2D2D2D2);
        chk("w4_off2_out1_pc", o1p4, 32'h200C);
        chk("w4_off2_out1_instr", o1i4, 32'hD3D3D3D3);
        a04 = 1'b1; a14 = 1'b1;
        @(posedge clk); #1;
        a04 = 1'b0; a14 = 1'b0;
        chk("w4_off2_empty", {31'd0, o0v4}, 32'd0);
        chk("w4_accept", {31'd0, facc4}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
